uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side byte buffer and launch controller, sitting directly upstream of the UART transmitter FSM. It accepts bytes from the processor's memory-mapped UART write path into a circular FIFO. It hands bytes one at a time to the transmitter over the transmitter's tx_start/din/tx_done_tick handshake, so software can queue a burst without polling per byte.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
AW, 4, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
wr_en  input  1  push wr_data this cycle
wr_data  input  8  byte to queue
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a push was attempted while full
clr_overflow  input  1  clears overflow
tx_start  output  1  one-cycle launch pulse to transmitter
din  output  8  byte presented to transmitter; registered, held until next launch
tx_done_tick  input  1  transmitter end-of-stop-bit pulse
tx_busy  output  1  high in LAUNCH or BUSY states

Behaviour:
- Reset (reset == 0 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, state=IDLE, tx_start=0, din=8'h00, overflow=0. Outputs after reset: empty=1, full=0, tx_busy=0. FIFO storage array is not reset.
- Reset mid-transfer discards all queued bytes and the byte in flight. The transmitter is reset by the same reset signal.
- Push: wr_en && !full writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (natural AW-bit wrap).
- wr_en && full: byte dropped; pointers and count unchanged; overflow <= 1.
- Full is evaluated on the current count. A push while full is dropped even if a pop happens in the same cycle.
- overflow: set has priority over clr_overflow in the same cycle.
- Pop: occurs only on the IDLE->LAUNCH transition. It loads din <= mem[rd_ptr] and increments rd_ptr modulo DEPTH.
- count: +1 on push only; -1 on pop only; unchanged when push and pop occur in the same cycle.
- FSM (registered), three states:
  - IDLE: if !empty, pop, set tx_start <= 1, go to LAUNCH; else stay.
  - LAUNCH: tx_start <= 0; go to BUSY unconditionally. tx_start is high for exactly this one cycle.
  - BUSY: wait; on tx_done_tick go to IDLE.
- tx_done_tick seen in IDLE or LAUNCH is ignored.
- Latency: push at edge N into an empty FIFO in IDLE -> empty deasserts after N -> pop at edge N+1 -> tx_start=1 and din valid during cycle N+2.
- Back-to-back bytes: tx_done_tick at cycle M -> IDLE during M+1 -> tx_start high during M+2. The transmitter has returned to its idle state by then.
- din changes only on a pop; it holds its value through BUSY and afterwards.
- The full DEPTH is usable: DEPTH pushes from empty with no pop gives full=1, count=DEPTH.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_en=1 -> count=0, empty=1, tx_start=0, din=00, overflow=0; no push recorded.
- Single byte: push 8'hA5 at edge N -> tx_start=1 only during cycle N+2 with din=A5; tx_busy=1; count returns to 0; pulse tx_done_tick -> IDLE, no further tx_start.
- Burst order: push 55,AA,0F,F0 back to back, then model tx_done_tick 20 cycles after each tx_start -> four tx_start pulses with din 55,AA,0F,F0 in order, each 2 cycles after the prior tx_done_tick.
- Full/overflow with the transmitter stalled (no tx_done_tick): push 18 bytes -> one byte goes to din, count reaches 16 and full=1, then the next push sets overflow=1 with count unchanged. Pulse clr_overflow -> overflow=0. Assert wr_en and clr_overflow together while full -> overflow stays 1.
- Wrap and simultaneous events: cycle 40 bytes through DEPTH=16 while pushing on the same cycles as pops -> count unchanged on those cycles, output order preserved across pointer wrap.
- Reset mid-operation: reset=0 while in BUSY with count=5 -> next cycle state IDLE, count=0, din=00. Then push 8'h3C -> tx_start 2 cycles later with din=3C.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit-side byte buffer and launch controller for a UART transmitter.
// Bytes written by the processor are queued in a circular FIFO. A three-state
// FSM hands them to the transmitter one at a time. It raises a one-cycle
// tx_start pulse with din loaded, then waits for the transmitter's
// tx_done_tick before launching the next byte.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   reset         synchronous active-low reset
//   wr_en         push wr_data this cycle (dropped when full)
//   wr_data       byte to queue
//   full          occupancy equals DEPTH
//   empty         occupancy is zero
//   count         current occupancy, 0..DEPTH
//   overflow      sticky flag: a push was attempted while full
//   clr_overflow  clears overflow (a same-cycle overflow event wins)
//   tx_start      one-cycle launch pulse to the transmitter
//   din           byte presented to the transmitter, held until the next launch
//   tx_done_tick  transmitter end-of-stop-bit pulse
//   tx_busy       high while a byte is being launched or transmitted
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          clr_overflow,
   output logic          tx_start,
   output logic [7:0]    din,
   input  logic          tx_done_tick,
   output logic          tx_busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2
   } state_t;

   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   state_t        state_r;
   logic          tx_start_r;
   logic [7:0]    din_r;
   logic          overflow_r;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;

   // Occupancy flags and push/pop qualification from the current count.
   // A push while full is refused even if a pop frees a slot this same cycle.
   always_comb begin
      full_s  = (count_r == DEPTH_CNT);
      empty_s = (count_r == CNT_ZERO);
      push_s  = wr_en & ~full_s;
      pop_s   = (state_r == IDLE) & ~empty_s;
   end

   // FIFO storage write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Write pointer, occupancy counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r   <= PTR_ZERO;
         count_r    <= CNT_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end

         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase

         // Setting wins over clearing so a refused push is never lost.
         if (wr_en && full_s) begin
            overflow_r <= 1'b1;
         end else if (clr_overflow) begin
            overflow_r <= 1'b0;
         end
      end
   end

   // Launch FSM: pops one byte in IDLE, pulses tx_start in LAUNCH, waits in BUSY.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         rd_ptr_r   <= PTR_ZERO;
         tx_start_r <= 1'b0;
         din_r      <= 8'h00;
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  din_r      <= mem_r[rd_ptr_r];
                  rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                  tx_start_r <= 1'b1;
                  state_r    <= LAUNCH;
               end else begin
                  tx_start_r <= 1'b0;
               end
            end
            LAUNCH: begin
               tx_start_r <= 1'b0;
               state_r    <= BUSY;
            end
            BUSY: begin
               tx_start_r <= 1'b0;
               if (tx_done_tick) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               tx_start_r <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

   assign full     = full_s;
   assign empty    = empty_s;
   assign count    = count_r;
   assign overflow = overflow_r;
   assign tx_start = tx_start_r;
   assign din      = din_r;
   assign tx_busy  = (state_r == LAUNCH) || (state_r == BUSY);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. Every queued byte that should be
// launched is pushed into exp_q at stimulus time. A monitor pops exp_q on each
// tx_start pulse and compares din. The monitor also measures the spacing
// between a tx_done_tick and the following launch. A small transmitter model
// produces tx_done_tick, either automatically 20 cycles after each launch or
// on explicit request from the stimulus process.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       clr_overflow;
   logic       tx_start;
   logic [7:0] din;
   logic       tx_done_tick;
   logic       tx_busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         launches = 0;
   logic [7:0] exp_q [$];

   bit         auto_done = 1'b0;
   bit         gap_chk = 1'b0;
   int         req_cnt = 0;

   uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .tx_start     (tx_start),
      .din          (din),
      .tx_done_tick (tx_done_tick),
      .tx_busy      (tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int limit, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (exp_q.size() == 0 && tx_busy === 1'b0 && empty === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   // Transmitter model: sole driver of tx_done_tick.
   initial begin
      int cd;
      int ack_cnt;
      cd = 0;
      ack_cnt = 0;
      tx_done_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tx_done_tick = 1'b0;
         if (tx_start === 1'b1 && auto_done) begin
            cd = 20;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) tx_done_tick = 1'b1;
         end
         if (req_cnt != ack_cnt) begin
            tx_done_tick = 1'b1;
            ack_cnt++;
         end
      end
   end

   // Monitor: compares every launched byte against the scoreboard.
   initial begin
      bit done_seen;
      int done_cyc;
      logic [7:0] e;
      done_seen = 1'b0;
      done_cyc = 0;
      forever begin
         @(negedge clk);
         if (tx_done_tick === 1'b1 && gap_chk) begin
            done_seen = 1'b1;
            done_cyc = cyc;
         end
         if (tx_start === 1'b1) begin
            launches++;
            if (exp_q.size() == 0) begin
               chk("unexpected_launch", 32'(din), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("launch_din", 32'(din), 32'(e));
            end
            if (gap_chk && done_seen) begin
               chk("done_to_start_gap", 32'(cyc - done_cyc), 32'd2);
            end
            done_seen = 1'b0;
         end
      end
   end

   // Absolute time limit so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus.
   initial begin
      logic [7:0] burst [4];
      int launches0;
      bit found;
      burst[0] = 8'h55; burst[1] = 8'hAA; burst[2] = 8'h0F; burst[3] = 8'hF0;

      // Reset held for two cycles with wr_en asserted.
      reset = 1'b0; wr_en = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b0;
      repeat (2) tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_din", 32'(din), 32'h00);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_tx_busy", 32'(tx_busy), 32'd0);
      reset = 1'b1; wr_en = 1'b0;
      repeat (3) tick();
      chk("rst_no_push", 32'(count), 32'd0);

      // Single byte: launch two cycles after the push edge.
      wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
      tick();
      wr_en = 1'b0;
      chk("single_n_tx_start", 32'(tx_start), 32'd0);
      chk("single_n_count", 32'(count), 32'd1);
      tick();
      chk("single_n2_tx_start", 32'(tx_start), 32'd1);
      chk("single_n2_din", 32'(din), 32'hA5);
      chk("single_n2_count", 32'(count), 32'd0);
      chk("single_n2_busy", 32'(tx_busy), 32'd1);
      tick();
      chk("single_pulse_len", 32'(tx_start), 32'd0);
      chk("single_busy_hold", 32'(tx_busy), 32'd1);
      req_cnt++;
      repeat (4) tick();
      chk("single_idle", 32'(tx_busy), 32'd0);
      chk("single_din_hold", 32'(din), 32'hA5);

      // Burst order with automatic done ticks.
      gap_chk = 1'b1; auto_done = 1'b1;
      launches0 = launches;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = burst[i]; exp_q.push_back(burst[i]);
         tick();
      end
      wr_en = 1'b0;
      wait_drain(400, "burst_drain");
      chk("burst_launches", 32'(launches - launches0), 32'd4);
      gap_chk = 1'b0; auto_done = 1'b0;

      // Full/overflow with a stalled transmitter: 18 pushes, last one dropped.
      for (int i = 0; i < 18; i++) begin
         wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
         if (i < 17) exp_q.push_back(8'h10 + 8'(i));
         tick();
         if (i == 16) begin
            chk("full_count16", 32'(count), 32'd16);
            chk("full_flag", 32'(full), 32'd1);
            chk("full_no_ovf_yet", 32'(overflow), 32'd0);
         end
      end
      wr_en = 1'b0;
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count_hold", 32'(count), 32'd16);
      chk("ovf_busy", 32'(tx_busy), 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      chk("ovf_clear", 32'(overflow), 32'd0);
      wr_en = 1'b1; wr_data = 8'hEE; clr_overflow = 1'b1;
      tick();
      wr_en = 1'b0; clr_overflow = 1'b0;
      chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
      chk("ovf_count_still16", 32'(count), 32'd16);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      auto_done = 1'b1;
      req_cnt++;
      wait_drain(2000, "full_drain");
      auto_done = 1'b0;

      // Wrap: 40 bytes, pushes coinciding with pops hold the count at 7.
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_data = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
         tick();
      end
      wr_en = 1'b0;
      chk("wrap_prefill_count", 32'(count), 32'd7);
      auto_done = 1'b1;
      req_cnt++;
      for (int i = 8; i < 40; i++) begin
         found = 1'b0;
         for (int k = 0; k < 60; k++) begin
            tick();
            if (tx_busy === 1'b0 && empty === 1'b0) begin
               found = 1'b1;
               break;
            end
         end
         chk("wrap_sync", 32'(found), 32'd1);
         if (!found) break;
         wr_en = 1'b1; wr_data = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
         tick();
         wr_en = 1'b0;
         chk("wrap_count_hold", 32'(count), 32'd7);
      end
      wait_drain(1000, "wrap_drain");
      auto_done = 1'b0;

      // Reset in BUSY with five bytes queued, then a fresh byte.
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
         if (i == 0) exp_q.push_back(8'h60);
         tick();
      end
      wr_en = 1'b0;
      chk("midrst_pre_count", 32'(count), 32'd5);
      chk("midrst_pre_busy", 32'(tx_busy), 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd1);
      chk("midrst_busy", 32'(tx_busy), 32'd0);
      chk("midrst_din", 32'(din), 32'h00);
      chk("midrst_tx_start", 32'(tx_start), 32'd0);
      wr_en = 1'b1; wr_data = 8'h3C; exp_q.push_back(8'h3C);
      tick();
      wr_en = 1'b0;
      chk("post_rst_n_tx_start", 32'(tx_start), 32'd0);
      tick();
      chk("post_rst_n2_tx_start", 32'(tx_start), 32'd1);
      chk("post_rst_n2_din", 32'(din), 32'h3C);
      repeat (3) tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
